fc_bank_drain: RTL and testbench

Read-side companion to the fully-connected layer's parallel result register bank. On a start pulse it snapshots DEPTH words of WIDTH bits in one cycle, then streams them out one word per beat, index 0 first, over a valid/ready interface. It sits between the FC compute array, which writes the bank, and the HPS-facing stream or FIFO path, which consumes results serially.

---
 rtl/fc_drain_pkg.sv | 22 ++
 rtl/fc_snapshot_reg.sv | 20 ++
 rtl/fc_bank_drain.sv | 98 +++++++++
 tb/tb_fc_bank_drain.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fc_drain_pkg.sv
// Shared types and helpers for the FC result-bank drain.
// Optional FC_DRAIN_PARITY_EN build uses even_par() for per-word parity.
package fc_drain_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   // Widest word the parity helper covers; narrower words are zero-extended.
   localparam int PAR_MAX_W = 64;

   function automatic int idx_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic logic even_par(input logic [PAR_MAX_W-1:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/fc_snapshot_reg.sv
// Flat DEPTH*WIDTH snapshot register: load enable, synchronous clear (wins over load).
module fc_snapshot_reg #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   load,
   input  logic                   clear,
   input  logic [DEPTH*WIDTH-1:0] d,
   output logic [DEPTH*WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      q <= '0;
      else if (clear) q <= '0;
      else if (load)  q <= d;
   end

endmodule

// File: rtl/fc_bank_drain.sv
// Snapshots the FC result bank on start and streams it out word by word (valid/ready).
// Define FC_DRAIN_PARITY_EN to add par_o, the stored even parity of each word.
module fc_bank_drain
   import fc_drain_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int IDX_W = idx_width(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start_i,
   input  logic                   clear_i,
   input  logic [DEPTH*WIDTH-1:0] bank_i,
   output logic                   busy_o,
   output logic                   m_valid_o,
   input  logic                   m_ready_i,
   output logic [WIDTH-1:0]       m_data_o,
   output logic [IDX_W-1:0]       m_idx_o,
   output logic                   m_last_o,
`ifdef FC_DRAIN_PARITY_EN
   output logic                   par_o,
`endif
   output logic                   done_o
);

   state_t                      state, nxt;
   logic [IDX_W-1:0]            idx;
   logic [DEPTH-1:0][WIDTH-1:0] snap;
   logic                        capture, beat, at_last;

   assign capture = (state == IDLE) & start_i & ~clear_i;
   assign beat    = (state == SEND) & m_ready_i;
   assign at_last = (idx == IDX_W'(DEPTH-1));

   fc_snapshot_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_snap (
      .clk   (clk),
      .rstn  (rstn),
      .load  (capture),
      .clear (clear_i),
      .d     (bank_i),
      .q     (snap)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (clear_i) nxt = IDLE;
      else begin
         case (state)
            IDLE:    if (start_i) nxt = SEND;
            SEND:    if (beat && at_last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   // idx never passes DEPTH-1; it returns to 0 on the way back to IDLE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                 idx <= '0;
      else if (clear_i)          idx <= '0;
      else if (capture)          idx <= '0;
      else if (beat && !at_last) idx <= idx + 1'b1;
      else if (state == DONE)    idx <= '0;
   end

   always_comb begin
      busy_o    = (state != IDLE);
      m_valid_o = (state == SEND);
      m_last_o  = (state == SEND) & at_last;
      done_o    = (state == DONE);
      m_idx_o   = idx;
      m_data_o  = '0;
      if (state == SEND) m_data_o = snap[idx];
   end

`ifdef FC_DRAIN_PARITY_EN
   logic [DEPTH-1:0] par_q, par_w;

   for (genvar k = 0; k < DEPTH; k++) begin : g_par
      assign par_w[k] = even_par(PAR_MAX_W'(bank_i[k*WIDTH +: WIDTH]));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        par_q <= '0;
      else if (clear_i) par_q <= '0;
      else if (capture) par_q <= par_w;
   end

   assign par_o = (state == SEND) & par_q[idx];
`endif

endmodule

// File: tb/tb_fc_bank_drain.sv
// Directed bench for fc_bank_drain: reset, full-rate, backpressure, ignored start, clear.
// Parity checks are active when FC_DRAIN_PARITY_EN is defined.
module tb_fc_bank_drain;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int IDX_W = 3;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic                   start_i, clear_i, m_ready_i;
   logic [DEPTH*WIDTH-1:0] bank_i;
   logic                   busy_o, m_valid_o, m_last_o, done_o;
   logic [WIDTH-1:0]       m_data_o;
   logic [IDX_W-1:0]       m_idx_o;
`ifdef FC_DRAIN_PARITY_EN
   logic                   par_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fc_bank_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start_i   (start_i),
      .clear_i   (clear_i),
      .bank_i    (bank_i),
      .busy_o    (busy_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i),
      .m_data_o  (m_data_o),
      .m_idx_o   (m_idx_o),
      .m_last_o  (m_last_o),
`ifdef FC_DRAIN_PARITY_EN
      .par_o     (par_o),
`endif
      .done_o    (done_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic load_bank(input logic [15:0] base, input logic [15:0] step_or);
      for (int k = 0; k < DEPTH; k++)
         bank_i[k*WIDTH +: WIDTH] = (step_or != 16'h0) ? 16'((32'h1 << (k+1)) - 1) : 16'(base + 16'(k));
   endtask

   task automatic chk_idle_out(input string tag);
      chk({tag, "_busy"},  32'(busy_o),    32'h0);
      chk({tag, "_valid"}, 32'(m_valid_o), 32'h0);
      chk({tag, "_data"},  32'(m_data_o),  32'h0);
      chk({tag, "_last"},  32'(m_last_o),  32'h0);
      chk({tag, "_done"},  32'(done_o),    32'h0);
`ifdef FC_DRAIN_PARITY_EN
      chk({tag, "_par"},   32'(par_o),     32'h0);
`endif
   endtask

   // Starts a drain and checks every cycle against a beat-counting model.
   // mode 0: words base+k; mode 1: words (2^(k+1))-1 for parity.
   task automatic drain(input logic [15:0] base, input logic [15:0] mode,
                        input int stall_lo, input int stall_hi, input int ign_at,
                        output int beats, output int done_c);
      int k;
      bit fin;
      logic [15:0] w;
      k = 0; beats = 0; done_c = 0; fin = 0;
      load_bank(base, mode);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 1; c <= 40 && !fin; c++) begin
         m_ready_i = !(c >= stall_lo && c <= stall_hi);
         start_i   = (c == ign_at);
         if (c == 3) bank_i = '1;
         w = (mode != 16'h0) ? 16'((32'h1 << (k+1)) - 1) : 16'(base + 16'(k));
         if (k < DEPTH) begin
            chk("valid", 32'(m_valid_o), 32'h1);
            chk("busy",  32'(busy_o),    32'h1);
            chk("data",  32'(m_data_o),  32'(w));
            chk("idx",   32'(m_idx_o),   32'(k));
            chk("last",  32'(m_last_o),  32'(k == DEPTH-1));
            chk("done_early", 32'(done_o), 32'h0);
`ifdef FC_DRAIN_PARITY_EN
            chk("par", 32'(par_o), 32'(^w));
`endif
            if (m_ready_i) k++;
         end else begin
            chk("done",       32'(done_o),    32'h1);
            chk("valid_done", 32'(m_valid_o), 32'h0);
            done_c = c;
            fin = 1;
         end
         if (m_valid_o && m_ready_i) beats++;
         @(negedge clk);
      end
      start_i   = 1'b0;
      m_ready_i = 1'b1;
      if (!fin) chk("timeout", 32'h0, 32'h1);
      for (int i = 0; i < 3; i++) begin
         chk_idle_out("after");
         @(negedge clk);
      end
   endtask

   initial begin
      int beats, done_c;
      rstn = 1'b0; start_i = 1'b1; clear_i = 1'b0; m_ready_i = 1'b1;
      bank_i = {$urandom, $urandom, $urandom, $urandom};

      // Reset held with start asserted: everything stays 0.
      repeat (3) @(negedge clk);
      chk_idle_out("rst");
      chk("rst_idx", 32'(m_idx_o), 32'h0);
      rstn = 1'b1; start_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rel_busy", 32'(busy_o), 32'h0);
      end

      // Full-rate: done 9 cycles after the start edge.
      drain(16'hA000, 16'h0, 0, -1, -1, beats, done_c);
      chk("full_beats", 32'(beats), 32'd8);
      chk("full_done_cyc", 32'(done_c), 32'd9);

      // Stall three cycles on word 1 and pulse a start that must be ignored.
      drain(16'hA000, 16'h0, 2, 4, 5, beats, done_c);
      chk("bp_beats", 32'(beats), 32'd8);
      chk("bp_done_cyc", 32'(done_c), 32'd12);

      // Clear after three beats.
      load_bank(16'hA000, 16'h0);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         chk("clr_pre_data", 32'(m_data_o), 32'(16'hA000 + 16'(c-1)));
         @(negedge clk);
      end
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      chk_idle_out("clr");
      chk("clr_idx", 32'(m_idx_o), 32'h0);
      @(negedge clk);
      chk("clr_done2", 32'(done_o), 32'h0);

      drain(16'hB000, 16'h0, 0, -1, -1, beats, done_c);
      chk("replay_beats", 32'(beats), 32'd8);

      // Start and clear together: no capture, no drain.
      load_bank(16'hC000, 16'h0);
      start_i = 1'b1; clear_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0; clear_i = 1'b0;
      chk_idle_out("sc");
      @(negedge clk);
      chk("sc_busy2", 32'(busy_o), 32'h0);

      // Parity-flavoured bank (0001, 0003, ...): parity 1,0,1,...
      drain(16'h0000, 16'h1, 0, -1, -1, beats, done_c);
      chk("par_beats", 32'(beats), 32'd8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
